// File: rtl/pipelined_unsigned_adder.sv
// -----------------------------------------------------------------------------
// pipelined_unsigned_adder
//
// Pipelined unsigned add/subtract unit with optional saturation. The WIDTH-bit
// carry chain is cut into STAGES equal slices. Stage k adds slice k using the
// carry registered by stage k-1, so each register level only sees a SW-bit
// ripple. Unconsumed operand bits travel down the pipe with the op, and
// finished result bits are carried forward. Saturation and the borrow flag are
// resolved in the last stage. The last stage's registers drive the outputs
// directly.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth = number of carry-chain slices = latency in cycles
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every stage (ops discarded)
//   in_valid   operands/controls valid
//   in_ready   unit accepts operands this cycle (= advance)
//   val_a      operand A, unsigned
//   val_b      operand B, unsigned
//   sub        0: A+B, 1: A-B
//   sat        1: saturate (add -> all ones, sub -> 0)
//   out_valid  result/flags valid
//   out_ready  downstream accepts result
//   result     sum/difference, wrapped or saturated
//   carry_out  add: carry out of MSB; sub: borrow (1 when A<B)
// -----------------------------------------------------------------------------
module pipelined_unsigned_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] val_a,
   input  logic [WIDTH-1:0] val_b,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam int SW = WIDTH / STAGES;

   // Per-stage pipeline registers
   logic             valid_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];   // B already inverted for subtract
   logic [WIDTH-1:0] s_q     [STAGES];   // result bits computed so far
   logic             c_q     [STAGES];   // slice carry (last stage: carry_out)
   logic             sub_q   [STAGES];
   logic             sat_q   [STAGES];

   logic             valid_d [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] s_d     [STAGES];
   logic             c_d     [STAGES];
   logic             sub_d   [STAGES];
   logic             sat_d   [STAGES];

   // What each stage sees at its input: the ports for stage 0, otherwise the
   // previous stage's registers.
   logic             src_valid [STAGES];
   logic [WIDTH-1:0] src_a     [STAGES];
   logic [WIDTH-1:0] src_b     [STAGES];
   logic [WIDTH-1:0] src_s     [STAGES];
   logic             src_c     [STAGES];
   logic             src_sub   [STAGES];
   logic             src_sat   [STAGES];

   logic advance;

   // The whole pipe moves in lockstep; only a stalled, occupied output stage
   // holds it back. No bubble collapsing.
   assign advance  = !valid_q[STAGES-1] || out_ready;
   assign in_ready = advance;

   // Stage 0 input: two's-complement subtract as A + ~B + 1.
   assign src_valid[0] = in_valid;
   assign src_a[0]     = val_a;
   assign src_b[0]     = sub ? ~val_b : val_b;
   assign src_s[0]     = '0;
   assign src_c[0]     = sub;
   assign src_sub[0]   = sub;
   assign src_sat[0]   = sat;

   generate
      for (genvar gi = 1; gi < STAGES; gi++) begin : g_link
         assign src_valid[gi] = valid_q[gi-1];
         assign src_a[gi]     = a_q[gi-1];
         assign src_b[gi]     = b_q[gi-1];
         assign src_s[gi]     = s_q[gi-1];
         assign src_c[gi]     = c_q[gi-1];
         assign src_sub[gi]   = sub_q[gi-1];
         assign src_sat[gi]   = sat_q[gi-1];
      end
   endgenerate

   always_comb begin
      logic [SW:0] slice_sum;
      slice_sum = '0;
      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = src_valid[k];
         a_d[k]     = src_a[k];
         b_d[k]     = src_b[k];
         sub_d[k]   = src_sub[k];
         sat_d[k]   = src_sat[k];

         slice_sum = {1'b0, src_a[k][k*SW +: SW]}
                   + {1'b0, src_b[k][k*SW +: SW]}
                   + {{SW{1'b0}}, src_c[k]};

         s_d[k]              = src_s[k];
         s_d[k][k*SW +: SW]  = slice_sum[SW-1:0];
         c_d[k]              = slice_sum[SW];

         // Last slice: slice_sum[SW] is the carry out of the full-width MSB.
         // For subtract a missing carry means a borrow (A < B).
         if (k == STAGES-1) begin
            if (src_sat[k] && !src_sub[k] && slice_sum[SW]) begin
               s_d[k] = '1;
            end else if (src_sat[k] && src_sub[k] && !slice_sum[SW]) begin
               s_d[k] = '0;
            end
            c_d[k] = src_sub[k] ? ~slice_sum[SW] : slice_sum[SW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            s_q[k]     <= '0;
            c_q[k]     <= 1'b0;
            sub_q[k]   <= 1'b0;
            sat_q[k]   <= 1'b0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            s_q[k]     <= s_d[k];
            c_q[k]     <= c_d[k];
            sub_q[k]   <= sub_d[k];
            sat_q[k]   <= sat_d[k];
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign result    = s_q[STAGES-1];
   assign carry_out = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_unsigned_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_unsigned_adder
//
// Four instances (16/2, 16/1, 16/4, 32/4) share stimulus; `sel` picks the one
// under test, the others see in_valid=0 and out_ready=1.
// -----------------------------------------------------------------------------
module tb_pipelined_unsigned_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        out_ready_i = 1'b1;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        sub_i = 1'b0;
   logic        sat_i = 1'b0;
   int          sel = 0;

   logic [3:0]  dv_in;
   logic [3:0]  dv_ordy;
   logic [3:0]  o_valid;
   logic [3:0]  i_ready;
   logic [3:0]  o_co;
   logic [31:0] o_res [4];
   logic [15:0] r0, r1, r2;
   logic [31:0] r3;

   int checks = 0;
   int failures = 0;
   int stg [4];
   int wid [4];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sel
         assign dv_in[gi]   = in_valid_i && (sel == gi);
         assign dv_ordy[gi] = (sel == gi) ? out_ready_i : 1'b1;
      end
   endgenerate

   assign o_res[0] = {16'h0, r0};
   assign o_res[1] = {16'h0, r1};
   assign o_res[2] = {16'h0, r2};
   assign o_res[3] = r3;

   pipelined_unsigned_adder #(.WIDTH(16), .STAGES(2)) u_w16_s2 (
      .clk(clk), .rst(rst), .in_valid(dv_in[0]), .in_ready(i_ready[0]),
      .val_a(a_i[15:0]), .val_b(b_i[15:0]), .sub(sub_i), .sat(sat_i),
      .out_valid(o_valid[0]), .out_ready(dv_ordy[0]), .result(r0), .carry_out(o_co[0]));

   pipelined_unsigned_adder #(.WIDTH(16), .STAGES(1)) u_w16_s1 (
      .clk(clk), .rst(rst), .in_valid(dv_in[1]), .in_ready(i_ready[1]),
      .val_a(a_i[15:0]), .val_b(b_i[15:0]), .sub(sub_i), .sat(sat_i),
      .out_valid(o_valid[1]), .out_ready(dv_ordy[1]), .result(r1), .carry_out(o_co[1]));

   pipelined_unsigned_adder #(.WIDTH(16), .STAGES(4)) u_w16_s4 (
      .clk(clk), .rst(rst), .in_valid(dv_in[2]), .in_ready(i_ready[2]),
      .val_a(a_i[15:0]), .val_b(b_i[15:0]), .sub(sub_i), .sat(sat_i),
      .out_valid(o_valid[2]), .out_ready(dv_ordy[2]), .result(r2), .carry_out(o_co[2]));

   pipelined_unsigned_adder #(.WIDTH(32), .STAGES(4)) u_w32_s4 (
      .clk(clk), .rst(rst), .in_valid(dv_in[3]), .in_ready(i_ready[3]),
      .val_a(a_i), .val_b(b_i), .sub(sub_i), .sat(sat_i),
      .out_valid(o_valid[3]), .out_ready(dv_ordy[3]), .result(r3), .carry_out(o_co[3]));

   // Directed vectors with hand-computed results for 16- and 32-bit widths
   logic [31:0] dv_a [9] = '{32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5,
                             32'h7, 32'h100, 32'hFFFF, 32'hFFFF};
   logic [31:0] dv_b [9] = '{32'h0FFF, 32'h2, 32'h2, 32'h7, 32'h7,
                             32'h5, 32'h1, 32'h1, 32'hFFFF};
   bit          dv_sub [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 1};
   bit          dv_sat [9] = '{0, 0, 1, 0, 1, 0, 0, 1, 1};
   logic [31:0] e16_r [9] = '{32'h2233, 32'h0001, 32'hFFFF, 32'hFFFE, 32'h0,
                              32'h2, 32'hFF, 32'hFFFF, 32'h0};
   bit          e16_c [9] = '{0, 1, 1, 1, 1, 0, 0, 1, 0};
   logic [31:0] e32_r [9] = '{32'h2233, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,
                              32'h2, 32'hFF, 32'h00010000, 32'h0};
   bit          e32_c [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

   // Stream operands
   logic [31:0] st_a [8] = '{32'hA5C31F2E, 32'h0000FFFF, 32'h80000001, 32'h12345678,
                             32'hFFFF0000, 32'h00000010, 32'h7FFFFFFF, 32'hDEADBEEF};
   logic [31:0] st_b [8] = '{32'h5A3CE0D2, 32'h00000001, 32'h80000001, 32'h87654321,
                             32'h0001FFFF, 32'h00000020, 32'h00000001, 32'hBEEFDEAD};
   bit          st_sub [8] = '{0, 0, 1, 1, 0, 1, 0, 1};
   bit          st_sat [8] = '{0, 1, 0, 1, 1, 1, 0, 0};

   // Reference: {carry_out, result} for a w-bit unit
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic t, input int w);
      logic [32:0] full;
      logic [31:0] mask;
      logic [31:0] r;
      logic        c;
      mask = (w == 32) ? 32'hFFFFFFFF : 32'h0000FFFF;
      full = {1'b0, a & mask} + {1'b0, (s ? ~b : b) & mask} + {32'h0, s};
      c    = (w == 32) ? full[32] : full[16];
      r    = full[31:0] & mask;
      if (t && !s && c) r = mask;
      else if (t && s && !c) r = 32'h0;
      return {(s ? ~c : c), r};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (o_valid[d] !== 1'b0 || o_res[d] !== 32'h0 || o_co[d] !== 1'b0 || i_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL reset_state dut%0d: out_valid=%b result=%h carry=%b in_ready=%b, required 0/0/0/1",
                     d, o_valid[d], o_res[d], o_co[d], i_ready[d]);
         end
      end
      $display("reset: state checked on all instances");
   endtask

   task automatic test_directed();
      int n;
      logic [31:0] er;
      bit ec;
      for (int v = 0; v < 9; v++) begin
         @(negedge clk);
         a_i = dv_a[v]; b_i = dv_b[v]; sub_i = dv_sub[v]; sat_i = dv_sat[v];
         in_valid_i = 1'b1;
         #1;
         checks++;
         if (i_ready[sel] !== 1'b1) begin
            failures++;
            $display("FAIL dir_in_ready dut%0d v%0d: in_ready=%b required 1", sel, v, i_ready[sel]);
         end
         @(posedge clk);
         @(negedge clk);
         in_valid_i = 1'b0;
         n = 1;
         while (o_valid[sel] !== 1'b1 && n <= 20) begin
            @(negedge clk);
            n++;
         end
         er = (wid[sel] == 32) ? e32_r[v] : e16_r[v];
         ec = (wid[sel] == 32) ? e32_c[v] : e16_c[v];
         checks++;
         if (n != stg[sel]) begin
            failures++;
            $display("FAIL dir_latency dut%0d v%0d: latency=%0d required %0d", sel, v, n, stg[sel]);
         end
         checks++;
         if (o_res[sel] !== er || o_co[sel] !== ec) begin
            failures++;
            $display("FAIL dir_result dut%0d v%0d: result=%h carry=%b required %h/%b",
                     sel, v, o_res[sel], o_co[sel], er, ec);
         end
         $display("dir dut%0d v%0d: a=%h b=%h sub=%b sat=%b -> %h c=%b latency=%0d",
                  sel, v, dv_a[v], dv_b[v], dv_sub[v], dv_sat[v], o_res[sel], o_co[sel], n);
      end
   endtask

   task automatic test_back_to_back(input bit stall);
      logic [32:0] exp_q [8];
      int sent, recv, cyc, first, last;
      bit will_accept, prev_hold;
      logic [31:0] prev_res;
      for (int i = 0; i < 8; i++) exp_q[i] = model(st_a[i], st_b[i], st_sub[i], st_sat[i], wid[sel]);
      sent = 0; recv = 0; cyc = 0; first = -1; last = -1;
      will_accept = 1'b0; prev_hold = 1'b0; prev_res = '0;
      while (recv < 8 && cyc < 100) begin
         @(negedge clk);
         if (will_accept) sent++;
         out_ready_i = !(stall && first >= 0 && cyc >= first + 2 && cyc < first + 5);
         if (sent < 8) begin
            a_i = st_a[sent]; b_i = st_b[sent]; sub_i = st_sub[sent]; sat_i = st_sat[sent];
            in_valid_i = 1'b1;
         end else begin
            in_valid_i = 1'b0;
         end
         #1;
         if (prev_hold) begin
            checks++;
            if (o_valid[sel] !== 1'b1 || o_res[sel] !== prev_res) begin
               failures++;
               $display("FAIL stall_hold dut%0d cyc%0d: out_valid=%b result=%h required 1/%h",
                        sel, cyc, o_valid[sel], o_res[sel], prev_res);
            end
         end
         if (!out_ready_i) begin
            checks++;
            if (i_ready[sel] !== 1'b0) begin
               failures++;
               $display("FAIL stall_in_ready dut%0d cyc%0d: in_ready=%b required 0", sel, cyc, i_ready[sel]);
            end
         end
         prev_hold = o_valid[sel] && !out_ready_i;
         prev_res  = o_res[sel];
         if (o_valid[sel] === 1'b1 && out_ready_i) begin
            checks++;
            if ({o_co[sel], o_res[sel]} !== exp_q[recv]) begin
               failures++;
               $display("FAIL stream_result dut%0d op%0d: got %h/%b required %h/%b", sel, recv,
                        o_res[sel], o_co[sel], exp_q[recv][31:0], exp_q[recv][32]);
            end
            $display("stream dut%0d op%0d: result=%h carry=%b", sel, recv, o_res[sel], o_co[sel]);
            if (first < 0) first = cyc;
            last = cyc;
            recv++;
         end
         will_accept = in_valid_i && i_ready[sel];
         cyc++;
      end
      @(negedge clk);
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      #1;
      checks++;
      if (recv != 8 || o_valid[sel] !== 1'b0) begin
         failures++;
         $display("FAIL stream_count dut%0d: received=%0d trailing_valid=%b required 8/0", sel, recv, o_valid[sel]);
      end
      if (!stall) begin
         checks++;
         if (last - first + 1 != 8) begin
            failures++;
            $display("FAIL stream_consecutive dut%0d: span=%0d required 8", sel, last - first + 1);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int n;
      bit stale;
      @(negedge clk);
      a_i = 32'h11; b_i = 32'h22; sub_i = 1'b0; sat_i = 1'b0; in_valid_i = 1'b1;
      @(negedge clk);
      a_i = 32'h33; b_i = 32'h44;
      @(negedge clk);
      a_i = 32'h55; b_i = 32'h66; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid_i = 1'b0;
      #1;
      checks++;
      if (o_valid[sel] !== 1'b0 || o_res[sel] !== 32'h0 || o_co[sel] !== 1'b0) begin
         failures++;
         $display("FAIL midreset_clear dut%0d: out_valid=%b result=%h carry=%b required 0/0/0",
                  sel, o_valid[sel], o_res[sel], o_co[sel]);
      end
      stale = 1'b0;
      repeat (stg[sel] + 3) begin
         @(negedge clk);
         if (o_valid[sel] !== 1'b0) stale = 1'b1;
      end
      checks++;
      if (stale) begin
         failures++;
         $display("FAIL midreset_stale dut%0d: out_valid=1 seen required 0", sel);
      end
      @(negedge clk);
      a_i = 32'h3; b_i = 32'h4; in_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_i = 1'b0;
      n = 1;
      while (o_valid[sel] !== 1'b1 && n <= 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != stg[sel] || o_res[sel] !== 32'h7 || o_co[sel] !== 1'b0) begin
         failures++;
         $display("FAIL midreset_next dut%0d: latency=%0d result=%h carry=%b required %0d/7/0",
                  sel, n, o_res[sel], o_co[sel], stg[sel]);
      end
      $display("midreset dut%0d: post-reset op latency=%0d result=%h", sel, n, o_res[sel]);
   endtask

   initial begin
      stg[0] = 2; stg[1] = 1; stg[2] = 4; stg[3] = 4;
      wid[0] = 16; wid[1] = 16; wid[2] = 16; wid[3] = 32;
      test_reset();
      for (int d = 0; d < 4; d++) begin
         sel = d;
         test_directed();
         test_back_to_back(1'b0);
         test_back_to_back(1'b1);
         test_reset_midstream();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
